// File: rtl/wb_arb_pkg.sv
// Shared types, response encodings and the round-robin helper for the
// Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic [1:0] RETURN_ACK = 2'b01;
    localparam logic [1:0] RETURN_ERR = 2'b10;

    localparam int MAX_MASTERS = 8;

    typedef struct packed {
        arb_state_t  state;
        logic [2:0]  grant_idx;
        logic [3:0]  outstanding;
    } arb_dbg_t;

    // First set bit in req strictly after last, wrapping modulo n; last itself is checked last.
    function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] last,
                                           input int n);
        logic [2:0] pick;
        logic       found;
        int         cand;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_MASTERS; i++) begin
            cand = (int'(last) + i) % n;
            if (i <= n && !found && req[3'(cand)]) begin
                pick  = 3'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: picks the next requester after last_idx.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [2:0] pick;

    always_comb begin
        pick      = rr_next(8'(req), 3'(last_idx), N);
        grant_idx = IDX_W'(pick);
        valid     = |req;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter (classic + pipelined), grant held for a whole CYC.
// Optional watchdog enabled with the WB_ARB_TIMEOUT_EN macro.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int GRANULE         = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_stall_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_stall_i,
    output arb_dbg_t                          dbg
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || MAX_OUTSTANDING < 1 ||
        MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("wb_rr_arbiter: parameter out of range");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [CNT_W-1:0] outstanding;
    logic             g_cyc;
    logic             full;
    logic             active;
    logic             accept;
    logic             resp;
    logic             fire;
    logic             hold_off;

    wb_rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
        .req       (m_cyc_i),
        .last_idx  (last_idx),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    // Handshake: a strobe is accepted in any cycle with s_stb_o=1 and s_stall_i=0;
    // each accepted strobe is retired by exactly one s_ack_i or s_err_i.
    assign g_cyc  = m_cyc_i[grant_idx];
    assign full   = (outstanding == CNT_W'(MAX_OUTSTANDING));
    assign active = (state == ARB_GRANT) && g_cyc && !hold_off;
    assign accept = s_stb_o && !s_stall_i;
    assign resp   = active && (s_ack_i || s_err_i);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            timed_out;

    assign hold_off = timed_out;
    assign fire     = active && (outstanding != '0) && !s_ack_i && !s_err_i &&
                      (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (state != ARB_GRANT || !g_cyc) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (fire) begin
            to_cnt    <= '0;
            timed_out <= 1'b1;
        end else if (timed_out || outstanding == '0 || s_ack_i || s_err_i) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign hold_off = 1'b0;
    assign fire     = 1'b0;
`endif

    always_comb begin
        s_cyc_o   = active;
        s_stb_o   = active && m_stb_i[grant_idx] && !full;
        s_we_o    = active && m_we_i[grant_idx];
        s_adr_o   = active ? m_adr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        s_dat_o   = active ? m_dat_i[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
        s_sel_o   = active ? m_sel_i[grant_idx*SEL_WIDTH +: SEL_WIDTH] : '0;
        m_dat_o   = active ? s_dat_i : '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        if (active) begin
            m_ack_o[grant_idx]   = s_ack_i;
            m_err_o[grant_idx]   = s_err_i || fire;
            m_stall_o[grant_idx] = s_stall_i || full;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ARB_IDLE;
            grant_idx   <= '0;
            last_idx    <= IDX_W'(NUM_MASTERS - 1);
            outstanding <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    outstanding <= '0;
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!g_cyc) begin
                        last_idx    <= grant_idx;
                        outstanding <= '0;
                        state       <= ARB_IDLE;
                    end else if (fire) begin
                        outstanding <= '0;
                    end else if (accept && !resp) begin
                        outstanding <= outstanding + CNT_W'(1);
                    end else if (resp && !accept && outstanding != '0) begin
                        // A stray response at zero is forwarded but never underflows the count.
                        outstanding <= outstanding - CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        dbg             = '0;
        dbg.state       = state;
        dbg.grant_idx   = 3'(grant_idx);
        dbg.outstanding = 4'(outstanding);
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (2 masters, MAX_OUTSTANDING=4).
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MO = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_stall_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_rdata;
    logic            s_ack, s_err, s_stall;
    arb_dbg_t        dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8),
        .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_rdata), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
        .dbg(dbg)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m_cyc[k]           = cyc;
        m_stb[k]           = stb;
        m_we[k]            = we;
        m_adr[k*AW +: AW]  = adr;
        m_dat[k*DW +: DW]  = dat;
        m_sel[k*SW +: SW]  = 4'hF;
    endtask

    task automatic idle_all();
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        m_cyc = 2'b11;
        settle();
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got %0h want 0", s_cyc_o); end
        checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_s_stb got %0h want 0", s_stb_o); end
        checks++; if (s_adr_o !== '0) begin errors++; $display("FAIL reset_s_adr got %0h want 0", s_adr_o); end
        checks++; if (m_stall_o !== 2'b11) begin errors++; $display("FAIL reset_stall got %0b want 11", m_stall_o); end
        checks++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin errors++; $display("FAIL reset_ack_err got %0b/%0b want 00/00", m_ack_o, m_err_o); end
        checks++; if (m_dat_o !== '0) begin errors++; $display("FAIL reset_m_dat got %0h want 0", m_dat_o); end
        checks++; if (dbg.state !== ARB_IDLE || dbg.outstanding !== 4'd0) begin errors++; $display("FAIL reset_state got %0h/%0d want IDLE/0", dbg.state, dbg.outstanding); end
        step();
        step();
        idle_all();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0004, 32'h0);
        settle();
        checks++; if (s_cyc_o !== 1'b0 || m_stall_o !== 2'b11) begin errors++; $display("FAIL single_arb_latency got cyc=%0h stall=%0b want 0/11", s_cyc_o, m_stall_o); end
        step();
        s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
        settle();
        checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b0) begin errors++; $display("FAIL single_s_ctrl got %0h%0h%0h want 110", s_cyc_o, s_stb_o, s_we_o); end
        checks++; if (s_adr_o !== 16'h0004 || s_sel_o !== 4'hF) begin errors++; $display("FAIL single_s_adr got %0h/%0h want 4/f", s_adr_o, s_sel_o); end
        checks++; if (m_ack_o !== 2'b01) begin errors++; $display("FAIL single_ack got %0b want 01", m_ack_o); end
        checks++; if (m_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %0h want deadbeef", m_dat_o); end
        checks++; if (m_stall_o !== 2'b10) begin errors++; $display("FAIL single_stall got %0b want 10", m_stall_o); end
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_ack = 1'b0; s_rdata = '0;
        settle();
        checks++; if (s_cyc_o !== 1'b0 || m_ack_o !== 2'b00) begin errors++; $display("FAIL single_release got cyc=%0h ack=%0b want 0/00", s_cyc_o, m_ack_o); end
        checks++; if (dbg.outstanding !== 4'd0) begin errors++; $display("FAIL single_outstanding got %0d want 0", dbg.outstanding); end
        step();
        checks++; if (dbg.state !== ARB_IDLE) begin errors++; $display("FAIL single_back_idle got %0h want IDLE", dbg.state); end
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        settle();
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0100, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0200, 32'h0);
        step();
        s_ack = 1'b1;
        settle();
        checks++; if (s_adr_o !== 16'h0100 || dbg.grant_idx !== 3'd0) begin errors++; $display("FAIL cont_first_winner got adr=%0h idx=%0d want 100/0", s_adr_o, dbg.grant_idx); end
        checks++; if (m_stall_o !== 2'b10 || m_ack_o !== 2'b01) begin errors++; $display("FAIL cont_m0_owner got stall=%0b ack=%0b want 10/01", m_stall_o, m_ack_o); end
        step();
        m_stb[0] = 1'b0; s_ack = 1'b0;
        settle();
        checks++; if (m_stall_o[1] !== 1'b1 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL cont_no_preempt got stall1=%0h cyc=%0h want 1/1", m_stall_o[1], s_cyc_o); end
        step();
        m_cyc[0] = 1'b0;
        settle();
        checks++; if (s_cyc_o !== 1'b0 || m_stall_o !== 2'b11) begin errors++; $display("FAIL cont_drop got cyc=%0h stall=%0b want 0/11", s_cyc_o, m_stall_o); end
        step();
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0100, 32'h0);
        settle();
        checks++; if (s_cyc_o !== 1'b0 || dbg.state !== ARB_IDLE) begin errors++; $display("FAIL cont_idle_gap got cyc=%0h st=%0h want 0/IDLE", s_cyc_o, dbg.state); end
        step();
        s_ack = 1'b1;
        settle();
        checks++; if (s_adr_o !== 16'h0200 || m_stall_o !== 2'b01 || m_ack_o !== 2'b10) begin errors++; $display("FAIL cont_m1_grant got adr=%0h stall=%0b ack=%0b want 200/01/10", s_adr_o, m_stall_o, m_ack_o); end
        step();
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_ack = 1'b0;
        step();
        step();
        settle();
        checks++; if (s_adr_o !== 16'h0100 || dbg.grant_idx !== 3'd0) begin errors++; $display("FAIL cont_m0_again got adr=%0h idx=%0d want 100/0", s_adr_o, dbg.grant_idx); end
        s_ack = 1'b1;
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_ack = 1'b0;
        step();
    endtask

    task automatic test_pipelined();
        int issued = 0;
        int acked = 0;
        int exp_out = 0;
        int cyc_n = 0;
        int due[$];
        logic saw_full = 1'b0;
        logic acc;
        logic [AW-1:0] exp_adr;
        drive(1, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h0);
        step();
        settle();
        checks++; if (s_cyc_o !== 1'b1 || dbg.grant_idx !== 3'd1) begin errors++; $display("FAIL pipe_grant got cyc=%0h idx=%0d want 1/1", s_cyc_o, dbg.grant_idx); end
        while (acked < 6 && cyc_n < 60) begin
            exp_adr = 16'h0010 + 16'(4 * issued);
            drive(1, 1'b1, issued < 6, 1'b1, exp_adr, 32'h1000 + 32'(issued));
            s_ack = (due.size() > 0) && (due[0] == cyc_n);
            settle();
            acc = (issued < 6) && (exp_out < MO);
            checks++; if (dbg.outstanding !== 4'(exp_out)) begin errors++; $display("FAIL pipe_count c%0d got %0d want %0d", cyc_n, dbg.outstanding, exp_out); end
            checks++; if (m_stall_o[1] !== (exp_out == MO)) begin errors++; $display("FAIL pipe_stall c%0d got %0h want %0h", cyc_n, m_stall_o[1], exp_out == MO); end
            checks++; if (s_stb_o !== acc || m_ack_o !== {s_ack, 1'b0}) begin errors++; $display("FAIL pipe_stb_ack c%0d got stb=%0h ack=%0b want %0h/%0b", cyc_n, s_stb_o, m_ack_o, acc, {s_ack, 1'b0}); end
            if (acc) begin
                checks++; if (s_adr_o !== exp_adr || s_we_o !== 1'b1) begin errors++; $display("FAIL pipe_adr c%0d got %0h want %0h", cyc_n, s_adr_o, exp_adr); end
            end
            if (exp_out == MO) saw_full = 1'b1;
            if (acc) begin due.push_back(cyc_n + 4); issued++; end
            if (s_ack) begin void'(due.pop_front()); acked++; end
            if (acc && !s_ack) exp_out++;
            else if (!acc && s_ack && exp_out > 0) exp_out--;
            step();
            cyc_n++;
        end
        s_ack = 1'b0;
        m_stb[1] = 1'b0;
        settle();
        checks++; if (acked != 6) begin errors++; $display("FAIL pipe_acks got %0d want 6", acked); end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL pipe_full_seen got %0h want 1", saw_full); end
        checks++; if (dbg.outstanding !== 4'd0 || m_stall_o[1] !== 1'b0) begin errors++; $display("FAIL pipe_drain got %0d/%0h want 0/0", dbg.outstanding, m_stall_o[1]); end
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
    endtask

    task automatic test_error();
        drive(0, 1'b1, 1'b1, 1'b1, 16'hFFFC, 32'hCAFE0000);
        step();
        s_err = 1'b1;
        settle();
        checks++; if ({m_err_o[0], m_ack_o[0]} !== RETURN_ERR || m_ack_o !== 2'b00) begin errors++; $display("FAIL err_route got err=%0b ack=%0b want 01/00", m_err_o, m_ack_o); end
        checks++; if (s_adr_o !== 16'hFFFC || s_we_o !== 1'b1 || s_dat_o !== 32'hCAFE0000) begin errors++; $display("FAIL err_s_bus got %0h/%0h/%0h want fffc/1/cafe0000", s_adr_o, s_we_o, s_dat_o); end
        step();
        s_err = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h0);
        settle();
        checks++; if (m_err_o !== 2'b00 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle got err=%0b cyc=%0h want 00/0", m_err_o, s_cyc_o); end
        step();
        step();
        s_ack = 1'b1; s_rdata = 32'h12345678;
        settle();
        checks++; if ({m_err_o[1], m_ack_o[1]} !== RETURN_ACK || m_err_o !== 2'b00 || m_dat_o !== 32'h12345678) begin errors++; $display("FAIL err_next_grant got ack=%0b err=%0b dat=%0h want 10/00/12345678", m_ack_o, m_err_o, m_dat_o); end
        step();
        s_ack = 1'b0; s_rdata = '0;
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0040, 32'h55);
        step();
        step();
        step();
        m_stb[0] = 1'b0;
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0050, 32'h0);
        settle();
        checks++; if (dbg.outstanding !== 4'd2 || dbg.grant_idx !== 3'd0) begin errors++; $display("FAIL rstmid_pre got out=%0d idx=%0d want 2/0", dbg.outstanding, dbg.grant_idx); end
        rst_n = 1'b0;
        s_ack = 1'b1;
        settle();
        checks++; if (s_cyc_o !== 1'b0 || m_stall_o !== 2'b11) begin errors++; $display("FAIL rstmid_drop got cyc=%0h stall=%0b want 0/11", s_cyc_o, m_stall_o); end
        checks++; if (m_ack_o !== 2'b00 || dbg.outstanding !== 4'd0) begin errors++; $display("FAIL rstmid_no_ack got ack=%0b out=%0d want 00/0", m_ack_o, dbg.outstanding); end
        step();
        s_ack = 1'b0;
        m_stb[0] = 1'b1;
        rst_n = 1'b1;
        step();
        settle();
        checks++; if (dbg.grant_idx !== 3'd0 || s_adr_o !== 16'h0040) begin errors++; $display("FAIL rstmid_winner got idx=%0d adr=%0h want 0/40", dbg.grant_idx, s_adr_o); end
        idle_all();
        step();
        step();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0080, 32'h0);
        step();
        settle();
        checks++; if (s_stb_o !== 1'b1) begin errors++; $display("FAIL to_accept got %0h want 1", s_stb_o); end
        step();
        m_stb[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            s_ack = (k == 10);
            settle();
            checks++; if (m_err_o !== {1'b0, k == TO} || m_ack_o !== 2'b00) begin errors++; $display("FAIL to_err k%0d got err=%0b ack=%0b want %0b/00", k, m_err_o, m_ack_o, {1'b0, k == TO}); end
            checks++; if (s_cyc_o !== (k <= TO)) begin errors++; $display("FAIL to_cyc k%0d got %0h want %0h", k, s_cyc_o, k <= TO); end
            step();
        end
        idle_all();
        step();
        step();
        checks++; if (dbg.state !== ARB_IDLE) begin errors++; $display("FAIL to_release got %0h want IDLE", dbg.state); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_pipelined();
        test_error();
        test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
